// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path.
// Holds the active-low 7-segment codes, the anode "all off" pattern, the
// scan state type and the leading-zero suppression rule used by the
// display scan driver.
package stopwatch_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // All anodes disabled (active-low).
    localparam logic [3:0] AN_OFF = 4'hF;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // A digit is a leading zero when it and every more-significant digit
    // are zero. The rightmost digit is always drawn so "0" stays visible.
    function automatic logic lz_suppress(input logic [15:0] digits,
                                         input logic [1:0]  idx);
        logic res;
        case (idx)
            2'd3:    res = (digits[15:12] == 4'h0);
            2'd2:    res = (digits[15:8]  == 8'h00);
            2'd1:    res = (digits[15:4]  == 12'h000);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd - 4-bit digit code; codes 10..15 are not decimal digits
//   seg - active-low segments {g,f,e,d,c,b,a}; non-decimal codes show a dash
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup; anything outside 0..9 renders as a dash.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Each rising edge of the divided display clock advances to the next digit,
// with all anodes held off for BLANK_CYC clk cycles before the new digit is
// drawn (anti-ghosting). Digit values are captured once per full scan so a
// running count never tears across digits.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-high reset
//   scan_clk  - divided display clock level, unrelated to clk edges
//   digits    - BCD digits, [3:0] = rightmost digit0 .. [15:12] = digit3
//   dp_in     - decimal point request per digit, 1 = on
//   blank_lz  - 1 = suppress leading zeros (only when LZ_EN = 1)
//   an        - anode enables, active-low, an[i] drives digit i
//   seg       - segments, active-low, {g,f,e,d,c,b,a}
//   dp        - decimal point, active-low
//   digit_idx - index of the currently selected digit
module seg_scan_driver
    import stopwatch_pkg::*;
#(
    parameter int BLANK_CYC = 2,
    parameter bit LZ_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_clk,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYC);

    logic        s1_r;
    logic        s2_r;
    logic        s3_r;
    logic        tick_s;

    scan_state_t state_r;
    logic [1:0]  idx_r;
    logic [3:0]  cnt_r;
    logic [15:0] snap_digits_r;
    logic [3:0]  snap_dp_r;

    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    logic [1:0]  idx_next_s;
    logic [3:0]  sel_bcd_s;
    logic [6:0]  dec_seg_s;
    logic        lz_blank_s;
    logic [3:0]  an_sel_s;
    logic        dp_sel_s;

    // Synchroniser (s1, s2) plus one delay stage (s3) for rising-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= scan_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign tick_s = s2_r & ~s3_r;

    // Select the snapshot digit for the current index and work out how it
    // should be drawn once the blanking gap ends.
    always_comb begin
        idx_next_s = idx_r + 2'd1;
        sel_bcd_s  = 4'h0;
        case (idx_r)
            2'd0:    sel_bcd_s = snap_digits_r[3:0];
            2'd1:    sel_bcd_s = snap_digits_r[7:4];
            2'd2:    sel_bcd_s = snap_digits_r[11:8];
            2'd3:    sel_bcd_s = snap_digits_r[15:12];
            default: sel_bcd_s = 4'h0;
        endcase
        lz_blank_s = LZ_EN && blank_lz && lz_suppress(snap_digits_r, idx_r);
        an_sel_s   = ~(4'b0001 << idx_r);
        dp_sel_s   = ~snap_dp_r[idx_r];
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (sel_bcd_s),
        .seg (dec_seg_s)
    );

    // Scan sequencer: tick -> blank gap -> show digit; ticks during the gap
    // are discarded. The snapshot is refreshed as the scan wraps to digit0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= OFF;
            idx_r         <= 2'd3;
            cnt_r         <= 4'd0;
            snap_digits_r <= 16'h0000;
            snap_dp_r     <= 4'h0;
            an_r          <= AN_OFF;
            seg_r         <= SEG_OFF;
            dp_r          <= 1'b1;
        end else begin
            case (state_r)
                OFF, SHOW: begin
                    if (tick_s) begin
                        idx_r   <= idx_next_s;
                        cnt_r   <= BLANK_LOAD;
                        state_r <= BLANK;
                        an_r    <= AN_OFF;
                        seg_r   <= SEG_OFF;
                        dp_r    <= 1'b1;
                        if (idx_next_s == 2'd0) begin
                            snap_digits_r <= digits;
                            snap_dp_r     <= dp_in;
                        end else begin
                            snap_digits_r <= snap_digits_r;
                            snap_dp_r     <= snap_dp_r;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                BLANK: begin
                    if (cnt_r == 4'd1) begin
                        cnt_r   <= 4'd0;
                        state_r <= SHOW;
                        an_r    <= an_sel_s;
                        seg_r   <= lz_blank_s ? SEG_OFF : dec_seg_s;
                        dp_r    <= dp_sel_s;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= OFF;
                    an_r    <= AN_OFF;
                    seg_r   <= SEG_OFF;
                    dp_r    <= 1'b1;
                end
            endcase
        end
    end

    assign an        = an_r;
    assign seg       = seg_r;
    assign dp        = dp_r;
    assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_clk;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.BLANK_CYC(BLANK_CYC), .LZ_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_clk  (scan_clk),
        .digits    (digits),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    // ---------------- reference model (event level) ----------------
    logic [6:0]  seg_tab [16];
    bit          samp_q [$];
    int          m_idx;
    int          m_gap;
    bit          m_show;
    logic [15:0] m_snap;
    logic [3:0]  m_sdp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    task automatic model_reset();
        samp_q = '{1'b0, 1'b0, 1'b0};
        m_idx = 3; m_gap = 0; m_show = 0; m_snap = 16'h0; m_sdp = 4'h0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    endtask

    // One clk rising edge: a scan_clk rise is seen two edges after it is sampled.
    task automatic model_edge();
        bit tick;
        logic [15:0] v;
        samp_q.push_back(scan_clk);
        while (samp_q.size() > 4) void'(samp_q.pop_front());
        tick = samp_q[1] && !samp_q[0];
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
                m_show = 1;
                v      = m_snap >> (4 * m_idx);
                e_an   = ~(4'b0001 << m_idx);
                e_seg  = (blank_lz && m_idx > 0 && v == 16'h0) ? 7'h7F : seg_tab[v[3:0]];
                e_dp   = ~m_sdp[m_idx];
            end
        end else if (tick) begin
            m_idx = (m_idx + 1) % 4;
            if (m_idx == 0) begin
                m_snap = digits;
                m_sdp  = dp_in;
            end
            m_gap  = BLANK_CYC;
            m_show = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        return {e_an, e_seg, e_dp, 2'(m_idx)};
    endfunction

    // Drive scan_clk between edges, advance one clk, model the edge, settle.
    task automatic clk_cycle(input logic sc);
        scan_clk = sc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        scan_clk = 1'b0; digits = 16'h1234; dp_in = 4'hF; blank_lz = 1'b0;
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            clk_cycle(1'b0);
            total++;
            if ({an, seg, dp, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd3}) begin
                bad++;
                $display("FAIL reset_idle c=%0d got=%h want=%h", c, {an, seg, dp, digit_idx},
                         {4'hF, 7'h7F, 1'b1, 2'd3});
            end
        end
    endtask

    task automatic test_scan_basic();
        int order [$];
        logic [3:0] prev_an;
        int want [5] = '{0, 1, 2, 3, 0};
        digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
        prev_an = 4'hF;
        for (int c = 0; c < 90; c++) begin
            clk_cycle(((c / 8) % 2) == 1);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL scan_basic c=%0d got=%h want=%h", c, {an, seg, dp, digit_idx}, exp_vec());
            end
            if (prev_an == 4'hF && an != 4'hF) order.push_back(int'(digit_idx));
            prev_an = an;
        end
        total++;
        if (order.size() < 5) begin
            bad++;
            $display("FAIL scan_order count got=%0d want>=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (order[i] != want[i]) begin
                    bad++;
                    $display("FAIL scan_order pos=%0d got=%0d want=%0d", i, order[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_lz();
        digits = 16'h0070; dp_in = 4'h0; blank_lz = 1'b1;
        for (int c = 0; c < 280; c++) begin
            if (c == 140) blank_lz = 1'b0;
            clk_cycle(((c / 8) % 2) == 1);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL lz c=%0d lz=%b got=%h want=%h", c, blank_lz, {an, seg, dp, digit_idx}, exp_vec());
            end
        end
    endtask

    task automatic test_snapshot();
        int c;
        bit seen;
        digits = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0;
        seen = 0;
        for (c = 0; c < 300; c++) begin
            if (!seen && m_idx == 1 && m_show && m_snap == 16'h0000) begin
                digits = 16'h9999;
                seen   = 1;
            end
            clk_cycle(((c / 8) % 2) == 1);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL snapshot c=%0d got=%h want=%h", c, {an, seg, dp, digit_idx}, exp_vec());
            end
            if (seen && m_snap == 16'h0000 && m_idx == 2 && m_show) begin
                total++;
                if (seg !== 7'b1000000) begin
                    bad++;
                    $display("FAIL snapshot_hold got=%b want=%b", seg, 7'b1000000);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL snapshot_timeout got=0 want=1");
        end
    endtask

    task automatic test_dash_dp();
        digits = 16'hA0F5; dp_in = 4'b0100; blank_lz = 1'b0;
        for (int c = 0; c < 160; c++) begin
            clk_cycle(((c / 8) % 2) == 1);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL dash_dp c=%0d got=%h want=%h", c, {an, seg, dp, digit_idx}, exp_vec());
            end
        end
    endtask

    task automatic test_drop();
        int start;
        logic pat [$] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 40 && (c < 6 || m_gap != 0); c++) clk_cycle(1'b0);
        start = m_idx;
        foreach (pat[i]) begin
            clk_cycle(pat[i]);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL drop c=%0d got=%h want=%h", i, {an, seg, dp, digit_idx}, exp_vec());
            end
            if (i == 9) begin
                total++;
                if (digit_idx !== 2'((start + 1) % 4)) begin
                    bad++;
                    $display("FAIL drop_once got=%0d want=%0d", digit_idx, (start + 1) % 4);
                end
            end
        end
        total++;
        if (digit_idx !== 2'((start + 2) % 4)) begin
            bad++;
            $display("FAIL wide_pulse_once got=%0d want=%0d", digit_idx, (start + 2) % 4);
        end
    endtask

    task automatic test_random();
        logic sc;
        int hold;
        sc = 1'b0;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                sc   = ~sc;
                hold = $urandom_range(1, 6);
            end
            hold--;
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            clk_cycle(sc);
            total++;
            if ({an, seg, dp, digit_idx} !== exp_vec()) begin
                bad++;
                $display("FAIL random c=%0d got=%h want=%h", c, {an, seg, dp, digit_idx}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        for (c = 0; c < 100 && !m_show; c++) clk_cycle(((c / 8) % 2) == 1);
        total++;
        if (!m_show || an === 4'hF) begin
            bad++;
            $display("FAIL reset_mid_setup got an=%h want digit shown", an);
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({an, seg, dp, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd3}) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", {an, seg, dp, digit_idx}, {4'hF, 7'h7F, 1'b1, 2'd3});
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        reset = 1'b1; scan_clk = 1'b0; digits = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
        model_reset();
        test_reset();
        test_scan_basic();
        test_lz();
        test_snapshot();
        test_dash_dp();
        test_drop();
        test_random();
        test_reset_mid();
        test_scan_basic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumer end of the display clock divider.
- Samples the divider's slow display clock level (scan_clk) in the system clock domain and turns each rising edge into a one-cycle scan tick.
- On each tick, steps a 4-digit, common-anode, 7-segment display through its digits, with a blanking gap between digits to prevent ghosting.
- Digit values are snapshotted once per full scan, so a running stopwatch count never tears across digits.

Parameters:
- BLANK_CYC, 2, clk cycles all anodes are held off between digits; legal range 1..15.
- LZ_EN, 1, 1 enables the leading-zero suppression logic; 0 ties it off and the blank_lz input is ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- scan_clk  in  1  divided display clock level from the divider; asynchronous to clk's edges in effect
- digits  in  16  BCD digits, [3:0] = digit0 (rightmost) … [15:12] = digit3
- dp_in  in  4  decimal point request per digit, 1 = on
- blank_lz  in  1  1 = suppress leading zeros
- an  out  4  anode enables, active-low, an[i] drives digit i
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- dp  out  1  decimal point, active-low
- digit_idx  out  2  index of the digit currently selected

Behaviour:
- Edge detect
  - scan_clk passes through a 2-flop synchroniser (s1, s2), then a third flop s3.
  - tick = s2 & ~s3.
  - A high pulse on scan_clk lasting at least 2 clk cycles yields exactly one tick.
- States: OFF (reset), BLANK, SHOW.
- Reset
  - Asynchronous.
  - State OFF, idx = 3, blank counter = 0, snapshot = 0.
  - an = 4'hF, seg = 7'h7F, dp = 1, digit_idx = 3.
  - Reset asserted mid-scan blanks the outputs immediately.
- On tick in OFF or SHOW
  - idx <= idx + 1 (wraps 3 -> 0).
  - cnt <= BLANK_CYC.
  - State -> BLANK.
  - an/seg/dp go all-off on that same edge.
  - If the new idx is 0, load the snapshot from digits and dp_in on that same edge.
- In BLANK
  - cnt decrements each cycle.
  - On the edge where cnt == 1: state -> SHOW, an[idx] = 0 (all others 1), seg = decode(snapshot digit idx), dp = ~snap_dp[idx].
  - Net effect: the new digit is visible BLANK_CYC edges after the tick edge.
- Ticks arriving in BLANK are dropped; they do not queue or extend the gap.
- digit_idx reflects idx; it updates on the tick edge.
- Outputs are registered; seg, an and dp change together.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes A–F show a dash: 0111111.
- Leading-zero suppression (LZ_EN=1 and blank_lz=1), evaluated on the snapshot:
  - digit3 is blanked if d3==0.
  - digit2 is blanked if d3==0 and d2==0.
  - digit1 is blanked if d3, d2 and d1 are all 0.
  - digit0 is never blanked.
  - A blanked digit keeps its anode active, with seg = 7'h7F.
  - dp is still shown if requested.
- Changes on digits or dp_in mid-scan have no effect until the next idx 3->0 transition.

Decomposition:
- Shared package stopwatch_pkg:
  - SEG_* active-low segment constants for 0–9, dash and off.
  - Scan state enum {OFF, BLANK, SHOW}.
  - AN_OFF = 4'hF.
- One natural sub-module: bcd_to_seg (combinational 4-bit -> 7-bit active-low decode, dash for invalid codes).
- Edge detect, FSM and snapshot stay in the top-level module.

Test Plan:
- Reset then no scan_clk activity -> an=F, seg=7F, dp=1, digit_idx=3 indefinitely; assert reset mid-SHOW -> all-off in the same cycle, without waiting for a clk edge.
- digits=16'h1234, dp_in=0, scan_clk toggling every 8 clk -> digit0 shows an=E, seg=0011001 ("4"), then digit1 shows an=D, seg=0110000 ("3"); each digit is preceded by exactly 2 cycles with an=F; scan order 0,1,2,3,0.
- digits=16'h0070, blank_lz=1 -> digit3 and digit2 show seg=7F with an active; digit1 "7" (1111000); digit0 "0" (1000000); repeat with blank_lz=0 -> all four digits drawn.
- Change digits from 16'h0000 to 16'h9999 while idx=1 -> digits 2 and 3 still show "0"; "9" (0010000) appears on all digits only after the next wrap to idx 0.
- digits=16'hA0F5, dp_in=4'b0100 -> digit3 and digit1 show dash 0111111; digit2 shows dp=0 when selected; digit0 shows "5".
- scan_clk pulse of 1 clk width, then a second rising edge 1 cycle after a tick (during BLANK) -> the second edge is dropped and idx advances only once; a 2-cycle-wide pulse -> exactly one advance.
